wb_uart_ctrl: RTL and testbench

//   Wishbone classic slave that sequences the uart core (rx/tx FIFOs) for a bus master.

---
 rtl/wb_uart_ctrl_if.sv | 33 +++
 rtl/wb_uart_ctrl.sv | 171 +++++++++++++++++
 tb/tb_wb_uart_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_ctrl_if.sv
// ---------------------------------------------------------------------------
// wb_uart_ctrl_if
// Wishbone classic bus bundle between a bus master and the wb_uart_ctrl slave.
//   cyc_i/stb_i/we_i : cycle, strobe and write-enable from the master
//   adr_i            : byte address (ADR_W bits)
//   sel_i            : byte enables (DATA_W/8 bits)
//   dat_i            : write data from the master
//   dat_o            : read data from the slave, valid while ack_o=1
//   ack_o            : one-cycle acknowledge from the slave
// ---------------------------------------------------------------------------
interface wb_uart_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 4
);
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [ADR_W-1:0]      wb_adr_i;
  logic [DATA_W/8-1:0]   wb_sel_i;
  logic [DATA_W-1:0]     wb_dat_i;
  logic [DATA_W-1:0]     wb_dat_o;
  logic                  wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_uart_ctrl.sv
// ---------------------------------------------------------------------------
// wb_uart_ctrl
// Wishbone classic slave that sequences a uart core's rx/tx FIFOs.
// Register map (adr[3:2]): 0 DATA (push/pop), 1 STATUS, 2 CTRL (irq enables),
// 3 DROP_CNT (tx bytes lost to a full FIFO, saturating, write clears).
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset
//   wb        : Wishbone slave modport (cyc/stb/we/adr/sel/dat_i, dat_o/ack)
//   irq       : level interrupt, registered
//   rd_uart   : one-cycle pop strobe to the rx FIFO (ACK cycle only)
//   wr_uart   : one-cycle push strobe to the tx FIFO (ACK cycle only)
//   w_data    : tx byte, valid with wr_uart
//   rd_data   : rx FIFO head (first-word fall-through)
//   rx_empty  : rx FIFO empty flag
//   tx_full   : tx FIFO full flag
// The interface instance must use the same DATA_W/ADR_W as this module.
// ---------------------------------------------------------------------------
module wb_uart_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_uart_ctrl_if.slave wb,
  output logic         irq,
  output logic         rd_uart,
  output logic         wr_uart,
  output logic [7:0]   w_data,
  input  logic [7:0]   rd_data,
  input  logic         rx_empty,
  input  logic         tx_full
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t              state_r;
  logic                ack_r;
  logic [DATA_W-1:0]   dat_o_r;
  logic                rd_uart_r;
  logic                wr_uart_r;
  logic [7:0]          w_data_r;
  logic                irq_r;
  logic                rx_ie_r;
  logic                tx_ie_r;
  logic [7:0]          drop_cnt_r;

  logic                accept_s;
  logic [1:0]          reg_sel_s;
  logic [DATA_W-1:0]   rdata_s;
  logic                unused_bits_s;

  // Saturating increment for the drop counter: sticks at 8'hFF.
  function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
    if (cnt == 8'hFF) begin
      return cnt;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

  // Access decode and read-data mux, evaluated against the flags at the accepting edge.
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && wb.wb_cyc_i && wb.wb_stb_i;
    reg_sel_s = wb.wb_adr_i[3:2];
    rdata_s   = '0;
    case (reg_sel_s)
      2'd0:    rdata_s[8:0] = {rx_empty, rd_data};
      2'd1:    rdata_s[1:0] = {tx_full, rx_empty};
      2'd2:    rdata_s[1:0] = {tx_ie_r, rx_ie_r};
      2'd3:    rdata_s[7:0] = drop_cnt_r;
      default: rdata_s      = '0;
    endcase
  end

  // Address/byte-lane/data bits that carry no meaning for this register file.
  assign unused_bits_s = ^{wb.wb_adr_i[1:0], wb.wb_sel_i[DATA_W/8-1:1], wb.wb_dat_i[DATA_W-1:8]};

  // Two-state access FSM; every output, register side effect and irq is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ack_r      <= 1'b0;
      dat_o_r    <= '0;
      rd_uart_r  <= 1'b0;
      wr_uart_r  <= 1'b0;
      w_data_r   <= 8'h00;
      irq_r      <= 1'b0;
      rx_ie_r    <= 1'b0;
      tx_ie_r    <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      irq_r <= (rx_ie_r && !rx_empty) || (tx_ie_r && !tx_full);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_ACK;
            ack_r     <= 1'b1;
            dat_o_r   <= wb.wb_we_i ? '0 : rdata_s;
            rd_uart_r <= 1'b0;
            wr_uart_r <= 1'b0;
            if (wb.wb_we_i) begin
              // Only byte lane 0 carries register data; other writes are no-ops.
              if (wb.wb_sel_i[0]) begin
                case (reg_sel_s)
                  2'd0: begin
                    if (!tx_full) begin
                      wr_uart_r <= 1'b1;
                      w_data_r  <= wb.wb_dat_i[7:0];
                    end else begin
                      drop_cnt_r <= sat_inc8(drop_cnt_r);
                    end
                  end
                  2'd1: begin
                    rx_ie_r <= rx_ie_r;
                  end
                  2'd2: begin
                    rx_ie_r <= wb.wb_dat_i[0];
                    tx_ie_r <= wb.wb_dat_i[1];
                  end
                  2'd3: begin
                    drop_cnt_r <= 8'h00;
                  end
                  default: begin
                    rx_ie_r <= rx_ie_r;
                  end
                endcase
              end else begin
                rx_ie_r <= rx_ie_r;
              end
            end else begin
              // Pop only when a valid byte was presented at the accepting edge.
              rd_uart_r <= (reg_sel_s == 2'd0) && !rx_empty;
            end
          end else begin
            ack_r     <= 1'b0;
            dat_o_r   <= '0;
            rd_uart_r <= 1'b0;
            wr_uart_r <= 1'b0;
          end
        end
        ST_ACK: begin
          // Unconditional return enforces the two-cycle minimum access spacing.
          state_r   <= ST_IDLE;
          ack_r     <= 1'b0;
          dat_o_r   <= '0;
          rd_uart_r <= 1'b0;
          wr_uart_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          ack_r     <= 1'b0;
          dat_o_r   <= '0;
          rd_uart_r <= 1'b0;
          wr_uart_r <= 1'b0;
        end
      endcase
    end
  end

  assign wb.wb_ack_o = ack_r;
  assign wb.wb_dat_o = dat_o_r;
  assign rd_uart     = rd_uart_r;
  assign wr_uart     = wr_uart_r;
  assign w_data      = w_data_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_wb_uart_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_uart_ctrl
// Self-checking bench for wb_uart_ctrl: a directed vector table, hand-written
// sequences for reset, drop saturation, irq timing and back-to-back strobes,
// then randomized accesses against a register-level reference model.
// ---------------------------------------------------------------------------
module tb_wb_uart_ctrl;

  logic       clk;
  logic       reset;
  logic       irq;
  logic       rd_uart;
  logic       wr_uart;
  logic [7:0] w_data;
  logic [7:0] rd_data;
  logic       rx_empty;
  logic       tx_full;

  int checks;
  int errors;

  // Reference model state: interrupt enables and drop count.
  logic m_rx_ie;
  logic m_tx_ie;
  int   m_drop;

  wb_uart_ctrl_if #(.DATA_W(32), .ADR_W(4)) wb ();

  wb_uart_ctrl #(.DATA_W(32), .ADR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb.slave),
    .irq      (irq),
    .rd_uart  (rd_uart),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .rd_data  (rd_data),
    .rx_empty (rx_empty),
    .tx_full  (tx_full)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        rxe;
    logic        txf;
    logic [7:0]  rdd;
    logic [31:0] exp_dat;
    logic        exp_wr;
    logic        exp_rd;
    logic [7:0]  exp_wd;
  } vec_t;

  vec_t vec [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input int r, input logic rxe, input logic txf,
                                             input logic [7:0] rdd);
    if (r == 0) return 32'(rxe) * 32'd256 + 32'(rdd);
    if (r == 1) return 32'(txf) * 32'd2 + 32'(rxe);
    if (r == 2) return 32'(m_tx_ie) * 32'd2 + 32'(m_rx_ie);
    return 32'(m_drop);
  endfunction

  task automatic model_update(input logic we, input int r, input logic [3:0] sel,
                              input logic [31:0] dat, input logic txf);
    if (we && sel[0]) begin
      if (r == 0 && txf) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      if (r == 2) begin
        m_rx_ie = dat[0];
        m_tx_ie = dat[1];
      end
      if (r == 3) m_drop = 0;
    end
  endtask

  task automatic model_reset();
    m_rx_ie = 1'b0;
    m_tx_ie = 1'b0;
    m_drop  = 0;
  endtask

  // One complete access, started on a falling edge and finishing on a falling edge.
  task automatic do_access(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic rxe, input logic txf,
                           input logic [7:0] rdd, input logic [31:0] exp_dat,
                           input logic exp_wr, input logic exp_rd, input logic [7:0] exp_wd,
                           input string tag);
    logic exp_irq;
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = we;
    wb.wb_adr_i = adr;
    wb.wb_sel_i = sel;
    wb.wb_dat_i = dat;
    rx_empty    = rxe;
    tx_full     = txf;
    rd_data     = rdd;
    @(posedge clk);
    #1;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    @(negedge clk);
    check({tag, " ack"}, 32'(wb.wb_ack_o), 32'd1);
    if (!we) check({tag, " dat_o"}, wb.wb_dat_o, exp_dat);
    check({tag, " wr_uart"}, 32'(wr_uart), 32'(exp_wr));
    check({tag, " rd_uart"}, 32'(rd_uart), 32'(exp_rd));
    if (exp_wr) check({tag, " w_data"}, 32'(w_data), 32'(exp_wd));
    model_update(we, int'(adr[3:2]), sel, dat, txf);
    @(posedge clk);
    @(negedge clk);
    check({tag, " ack_end"}, 32'(wb.wb_ack_o), 32'd0);
    check({tag, " strobes_end"}, {30'd0, wr_uart, rd_uart}, 32'd0);
    exp_irq = (m_rx_ie && !rxe) || (m_tx_ie && !txf);
    check({tag, " irq"}, 32'(irq), 32'(exp_irq));
  endtask

  initial begin
    logic        r_we;
    logic [3:0]  r_adr;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic        r_rxe;
    logic        r_txf;
    logic [7:0]  r_rdd;
    logic        f_rxe;
    logic        f_txf;
    logic        e_wr;
    logic        e_rd;

    checks = 0;
    errors = 0;
    model_reset();

    //            we    adr    sel    dat            rxe   txf   rdd    exp_dat        wr    rd    wd
    vec[0]  = '{1'b1, 4'h0, 4'h1, 32'h000000A5, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b1, 1'b0, 8'hA5};
    vec[1]  = '{1'b1, 4'h8, 4'hF, 32'hFFFFFFF3, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[2]  = '{1'b0, 4'h8, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000003, 1'b0, 1'b0, 8'h00};
    vec[3]  = '{1'b1, 4'h8, 4'hE, 32'h00000002, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[4]  = '{1'b0, 4'h8, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000003, 1'b0, 1'b0, 8'h00};
    vec[5]  = '{1'b0, 4'h0, 4'hF, 32'h00000000, 1'b0, 1'b0, 8'h3C, 32'h0000003C, 1'b0, 1'b1, 8'h00};
    vec[6]  = '{1'b0, 4'h0, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000100, 1'b0, 1'b0, 8'h00};
    vec[7]  = '{1'b0, 4'h4, 4'hF, 32'h00000000, 1'b1, 1'b1, 8'h00, 32'h00000003, 1'b0, 1'b0, 8'h00};
    vec[8]  = '{1'b1, 4'h0, 4'h1, 32'h00000077, 1'b1, 1'b1, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[9]  = '{1'b0, 4'hC, 4'hF, 32'h00000000, 1'b1, 1'b1, 8'h00, 32'h00000001, 1'b0, 1'b0, 8'h00};
    vec[10] = '{1'b1, 4'h4, 4'hF, 32'h000000FF, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[11] = '{1'b0, 4'h4, 4'hF, 32'h00000000, 1'b0, 1'b0, 8'h11, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[12] = '{1'b1, 4'h0, 4'h0, 32'h00000055, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[13] = '{1'b0, 4'hC, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000001, 1'b0, 1'b0, 8'h00};
    vec[14] = '{1'b1, 4'hC, 4'h1, 32'h12345678, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[15] = '{1'b0, 4'hC, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[16] = '{1'b1, 4'h8, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[17] = '{1'b0, 4'h8, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};
    vec[18] = '{1'b0, 4'h0, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h7E, 32'h0000017E, 1'b0, 1'b0, 8'h00};
    vec[19] = '{1'b0, 4'h9, 4'hF, 32'h00000000, 1'b1, 1'b0, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00};

    // Reset state.
    reset       = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 4'h0;
    wb.wb_sel_i = 4'h0;
    wb.wb_dat_i = 32'h0;
    rd_data     = 8'h00;
    rx_empty    = 1'b1;
    tx_full     = 1'b0;
    #13;
    check("reset ack", 32'(wb.wb_ack_o), 32'd0);
    check("reset dat_o", wb.wb_dat_o, 32'd0);
    check("reset strobes", {30'd0, wr_uart, rd_uart}, 32'd0);
    check("reset w_data", 32'(w_data), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      do_access(vec[i].we, vec[i].adr, vec[i].sel, vec[i].dat, vec[i].rxe, vec[i].txf,
                vec[i].rdd, vec[i].exp_dat, vec[i].exp_wr, vec[i].exp_rd, vec[i].exp_wd,
                $sformatf("vec%0d", i));
    end

    // Drop counter saturation with the tx FIFO full.
    for (int i = 0; i < 300; i++) begin
      do_access(1'b1, 4'h0, 4'h1, 32'(i), 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "drop_wr");
    end
    do_access(1'b0, 4'hC, 4'hF, 32'h0, 1'b1, 1'b1, 8'h00, 32'h000000FF, 1'b0, 1'b0, 8'h00, "drop_sat");
    do_access(1'b1, 4'hC, 4'h1, 32'h0, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "drop_clr_wr");
    do_access(1'b0, 4'hC, 4'hF, 32'h0, 1'b1, 1'b1, 8'h00, 32'h00000000, 1'b0, 1'b0, 8'h00, "drop_clr");

    // Reset asserted in the ACK cycle of a DATA write.
    do_access(1'b1, 4'h8, 4'h1, 32'h3, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "rst_ctrl");
    do_access(1'b1, 4'h0, 4'h1, 32'h9, 1'b0, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "rst_drop");
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b1;
    wb.wb_adr_i = 4'h0;
    wb.wb_sel_i = 4'h1;
    wb.wb_dat_i = 32'hA5;
    tx_full     = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst ack", 32'(wb.wb_ack_o), 32'd0);
    check("midrst wr_uart", 32'(wr_uart), 32'd0);
    check("midrst irq", 32'(irq), 32'd0);
    check("midrst w_data", 32'(w_data), 32'd0);
    wb.wb_cyc_i = 1'b0;
    wb.wb_stb_i = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst irq", 32'(irq), 32'd0);
    do_access(1'b0, 4'h8, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "postrst_ctrl");
    do_access(1'b0, 4'hC, 4'hF, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "postrst_drop");
    do_access(1'b1, 4'h0, 4'h1, 32'h5A, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h5A, "postrst_wr");

    // Interrupt timing.
    do_access(1'b1, 4'h8, 4'h1, 32'h1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "irq_ctrl1");
    rx_empty = 1'b0;
    #1;
    check("irq rise lag", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq rise", 32'(irq), 32'd1);
    do_access(1'b0, 4'h0, 4'hF, 32'h0, 1'b0, 1'b1, 8'h42, 32'h00000042, 1'b0, 1'b1, 8'h00, "irq_pop");
    rx_empty = 1'b1;
    #1;
    check("irq fall lag", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq fall", 32'(irq), 32'd0);
    do_access(1'b1, 4'h8, 4'h1, 32'h2, 1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, "irq_ctrl2");
    check("irq tx", 32'(irq), 32'd1);

    // Back-to-back STATUS reads with stb held high.
    wb.wb_cyc_i = 1'b1;
    wb.wb_stb_i = 1'b1;
    wb.wb_we_i  = 1'b0;
    wb.wb_adr_i = 4'h4;
    wb.wb_sel_i = 4'hF;
    for (int k = 0; k < 3; k++) begin
      f_rxe    = 1'($urandom_range(0, 1));
      f_txf    = 1'($urandom_range(0, 1));
      rx_empty = f_rxe;
      tx_full  = f_txf;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d ack", k), 32'(wb.wb_ack_o), 32'd1);
      check($sformatf("b2b%0d dat_o", k), wb.wb_dat_o, {30'd0, f_txf, f_rxe});
      if (k == 2) begin
        wb.wb_cyc_i = 1'b0;
        wb.wb_stb_i = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d gap", k), 32'(wb.wb_ack_o), 32'd0);
    end

    // Randomized accesses against the reference model.
    for (int i = 0; i < 200; i++) begin
      r_we  = 1'($urandom_range(0, 1));
      r_adr = 4'($urandom_range(0, 15));
      r_sel = 4'($urandom_range(0, 15));
      r_dat = $urandom;
      r_rxe = 1'($urandom_range(0, 1));
      r_txf = 1'($urandom_range(0, 1));
      r_rdd = 8'($urandom_range(0, 255));
      e_wr  = r_we && r_sel[0] && (r_adr[3:2] == 2'd0) && !r_txf;
      e_rd  = !r_we && (r_adr[3:2] == 2'd0) && !r_rxe;
      do_access(r_we, r_adr, r_sel, r_dat, r_rxe, r_txf, r_rdd,
                model_read(int'(r_adr[3:2]), r_rxe, r_txf, r_rdd),
                e_wr, e_rd, r_dat[7:0], $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
